// File: rtl/wlmont_pkg.sv
// Shared definitions for the word-level Montgomery datapath: encoder FSM
// states, the Montgomery exponent helper and the encoder latency.
// Build option: WLMONT_ENC_PRERED_EN adds one pre-reduction cycle so the
// encoder accepts operands in [0, 2q).
package wlmont_pkg;

  // Encoder FSM states; S_PRE is only reachable when pre-reduction is built in.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } enc_state_e;

  // Montgomery exponent RLOG = L*(W-1); the reduction unit consumes W-1 bits
  // per loop iteration, so the encoder must pre-scale by the same amount.
  function automatic int rlog_f(input int w, input int l);
    return l * (w - 1);
  endfunction

  localparam int W_DEFAULT    = 15;
  localparam int L_DEFAULT    = 4;
  localparam int RLOG_DEFAULT = rlog_f(W_DEFAULT, L_DEFAULT);

`ifdef WLMONT_ENC_PRERED_EN
  localparam int PRE_CYCLES = 1;
`else
  localparam int PRE_CYCLES = 0;
`endif

  // Accept-to-out_valid latency in clock edges for the default configuration.
  localparam int ENC_LATENCY = RLOG_DEFAULT + PRE_CYCLES;

  // Same latency for an arbitrary exponent.
  function automatic int enc_latency_f(input int rlog);
    return rlog + PRE_CYCLES;
  endfunction

endpackage

// File: rtl/wlmont_dbl.sv
// One combinational modular-doubling step: dbl_o = (2*acc_i) mod q_i,
// valid whenever acc_i < q_i. Kept separate so a later revision can chain
// several steps per cycle.
module wlmont_dbl #(
  parameter int LOGQ = 60
) (
  input  logic [LOGQ-1:0] acc_i,
  input  logic [LOGQ-1:0] q_i,
  output logic [LOGQ-1:0] dbl_o
);

  logic [LOGQ:0] dbl_full;
  logic          below_q;

  // The doubled value needs one extra bit before the conditional subtract.
  assign dbl_full = {acc_i, 1'b0};

  // Equivalent to the sign of (2*acc - q); since 2*acc < 2q the corrected
  // value always fits back into LOGQ bits, so the subtract can be done at
  // LOGQ width and the carry out discarded.
  assign below_q = dbl_full < {1'b0, q_i};

  assign dbl_o = below_q ? dbl_full[LOGQ-1:0] : (dbl_full[LOGQ-1:0] - q_i);

endmodule

// File: rtl/wlmont_enc.sv
// Iterative encoder into the word-level Montgomery domain:
// y = x * 2^RLOG mod q, one modular doubling per clock, valid/ready on both
// sides, one operand in flight.
// Build option: WLMONT_ENC_PRERED_EN inserts a pre-reduction cycle (x < 2q).
module wlmont_enc
  import wlmont_pkg::*;
#(
  parameter int LOGQ = 60,
  parameter int W    = W_DEFAULT,
  parameter int L    = L_DEFAULT,
  parameter int RLOG = rlog_f(W, L)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LOGQ-1:0] q,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LOGQ-1:0] x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] y
);

  localparam int             CW       = $clog2(RLOG + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(RLOG - 1);

  enc_state_e       state_q;
  logic [LOGQ-1:0]  acc_q;
  logic [LOGQ-1:0]  qr_q;
  logic [CW-1:0]    cnt_q;
  logic [LOGQ-1:0]  y_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [LOGQ-1:0]  acc_d;

  // Next accumulator value for one doubling step.
  wlmont_dbl #(
    .LOGQ (LOGQ)
  ) u_dbl (
    .acc_i (acc_q),
    .q_i   (qr_q),
    .dbl_o (acc_d)
  );

`ifdef WLMONT_ENC_PRERED_EN
  logic            pre_ge;
  logic [LOGQ-1:0] pre_diff;

  // Single conditional subtract brings x in [0, 2q) into [0, q).
  assign pre_ge   = acc_q >= qr_q;
  assign pre_diff = acc_q - qr_q;
`endif

  // FSM, operand registers, counter and registered handshake outputs.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would let later lines see half-updated state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, so y reads 0 out of reset
      // and an aborted operand leaves no stale value behind.
      state_q     <= S_IDLE;
      acc_q       <= '0;
      qr_q        <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            acc_q      <= x;
            qr_q       <= q;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
`ifdef WLMONT_ENC_PRERED_EN
            state_q    <= S_PRE;
`else
            state_q    <= S_RUN;
`endif
          end else begin
            // First cycle out of reset lands here with in_ready still low.
            in_ready_q <= 1'b1;
          end
        end

`ifdef WLMONT_ENC_PRERED_EN
        S_PRE: begin
          if (pre_ge) begin
            acc_q <= pre_diff;
          end
          state_q <= S_RUN;
        end
`endif

        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            y_q         <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_DONE: begin
          // in_valid is ignored here; a new operand waits for IDLE.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_wlmont_enc.sv
// Self-checking bench for wlmont_enc: a small instance (LOGQ=8, RLOG=8,
// q=251) driven from a vector table plus hand-written backpressure, DONE
// collision and mid-run reset sequences, and a default instance (LOGQ=60,
// RLOG=56) driven with random operands against an arithmetic model.
module tb_wlmont_enc;

`ifdef WLMONT_ENC_PRERED_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif

  localparam int          LAT_S = 8 + PRE;
  localparam int          LAT_D = 56 + PRE;
  localparam logic [7:0]  Q_S   = 8'd251;
  localparam logic [59:0] Q_D   = 60'hFFF_FFFF_FFFF_C001;

  logic clk = 1'b0;
  logic rst;

  logic [7:0]  s_q, s_x, s_y;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [59:0] d_q, d_x, d_y;
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wlmont_enc #(.LOGQ(8), .W(3), .L(4)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .q         (s_q),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .x         (s_x),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .y         (s_y)
  );

  wlmont_enc dut_d (
    .clk       (clk),
    .rst       (rst),
    .q         (d_q),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .x         (d_x),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .y         (d_y)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: x * 2^56 mod q using wide plain arithmetic.
  function automatic logic [59:0] ref_d(input logic [59:0] xv);
    logic [127:0] p;
    p = {68'd0, xv} << 56;
    return 60'(p % {68'd0, Q_D});
  endfunction

  // One transaction on the small instance. Called at a falling edge.
  // hold: cycles out_ready stays low after out_valid; stuff_x: if nonzero,
  // present that next operand during DONE to check it is not taken early.
  task automatic s_op(input logic [7:0] xv, input logic [7:0] ev, input int hold,
                      input logic [7:0] stuff_x, input string tag);
    int n;
    int bad;
    logic [7:0] y0;
    n = 0;
    while (!s_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready_wait"}, 64'(s_in_ready), 64'd1);
    s_in_valid  = 1'b1;
    s_x         = xv;
    s_q         = Q_S;
    s_out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    // Operand and modulus changes after accept must be ignored.
    s_in_valid = 1'b0;
    s_x        = 8'($urandom);
    s_q        = 8'($urandom) | 8'h01;
    check({tag, " busy"}, 64'(s_in_ready), 64'd0);
    n = 0;
    while (!s_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(LAT_S));
    check({tag, " y"}, 64'(s_y), 64'(ev));
    s_q = Q_S;
    if (stuff_x != 8'd0) begin
      s_in_valid = 1'b1;
      s_x        = stuff_x;
    end
    y0  = s_y;
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (s_y !== y0 || s_out_valid !== 1'b1 || s_in_ready !== 1'b0) bad++;
    end
    check({tag, " hold_stable"}, 64'(bad), 64'd0);
    s_out_ready = 1'b1;
    @(negedge clk);
    check({tag, " out_valid_drop"}, 64'(s_out_valid), 64'd0);
    check({tag, " ready_after"}, 64'(s_in_ready), 64'd1);
    s_out_ready = 1'b0;
  endtask

  // One transaction on the default instance with out_ready held high.
  task automatic d_op(input logic [59:0] xv, input string tag);
    int n;
    n = 0;
    while (!d_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready_wait"}, 64'(d_in_ready), 64'd1);
    d_in_valid = 1'b1;
    d_x        = xv;
    @(posedge clk);
    @(negedge clk);
    d_in_valid = 1'b0;
    d_x        = {$urandom(), 28'($urandom())};
    n = 0;
    while (!d_out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(LAT_D));
    check({tag, " y"}, 64'(d_y), 64'(ref_d(xv)));
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    int         hold;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic [63:0] r;
    logic [59:0] xd;

    tbl.push_back('{8'd1,   8'd5,   0});
    tbl.push_back('{8'd250, 8'd246, 0});
    tbl.push_back('{8'd0,   8'd0,   0});
    tbl.push_back('{8'd2,   8'd10,  3});
    tbl.push_back('{8'd125, 8'd123, 0});
    tbl.push_back('{8'd200, 8'd247, 1});
    tbl.push_back('{8'd50,  8'd250, 0});
    tbl.push_back('{8'd100, 8'd249, 20});
`ifdef WLMONT_ENC_PRERED_EN
    tbl.push_back('{8'd252, 8'd5,   0});
    tbl.push_back('{8'd251, 8'd0,   0});
`endif

    rst = 1'b1;
    s_q = Q_S; s_x = '0; s_in_valid = 1'b0; s_out_ready = 1'b0;
    d_q = Q_D; d_x = '0; d_in_valid = 1'b0; d_out_ready = 1'b1;

    #1;
    check("rst s_in_ready", 64'(s_in_ready), 64'd0);
    check("rst s_out_valid", 64'(s_out_valid), 64'd0);
    check("rst s_y", 64'(s_y), 64'd0);
    check("rst d_in_ready", 64'(d_in_ready), 64'd0);
    check("rst d_y", 64'(d_y), 64'd0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("release s_in_ready", 64'(s_in_ready), 64'd0);
    @(negedge clk);
    check("first edge s_in_ready", 64'(s_in_ready), 64'd1);
    check("first edge d_in_ready", 64'(d_in_ready), 64'd1);

    // Table-driven vectors on the small instance.
    foreach (tbl[i]) begin
      s_op(tbl[i].x, tbl[i].y, tbl[i].hold, 8'd0, $sformatf("vec%0d", i));
    end

    // New operand presented during DONE: only the output handshake happens,
    // then the held operand (x=3) is accepted from IDLE.
    s_op(8'd7, 8'd35, 2, 8'd3, "collide_a");
    s_op(8'd3, 8'd15, 0, 8'd0, "collide_b");

    // Mid-RUN reset at cnt=4.
    s_in_valid = 1'b1;
    s_x        = 8'd1;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst out_valid", 64'(s_out_valid), 64'd0);
    check("midrst in_ready", 64'(s_in_ready), 64'd0);
    check("midrst y", 64'(s_y), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midrst release in_ready", 64'(s_in_ready), 64'd0);
    @(negedge clk);
    check("midrst ready rises", 64'(s_in_ready), 64'd1);
    check("midrst no output", 64'(s_out_valid), 64'd0);
    s_op(8'd1, 8'd5, 0, 8'd0, "after_rst");

    // Default instance: corners then random operands below q.
    d_op(60'd0, "d_zero");
    d_op(60'd1, "d_one");
    d_op(Q_D - 60'd1, "d_qm1");
    for (int i = 0; i < 1000; i++) begin
      r  = {$urandom(), $urandom()};
      xd = r[59:0];
      if (xd >= Q_D) xd = xd - Q_D;
      d_op(xd, $sformatf("d_rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
